// File: rtl/fifo_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_package
// Shared types and constants for the FIFO stream reader and its skid buffer.
//   DATA_W_DEF    : default FIFO / stream data width
//   BEAT_W        : width of the burst position counter, sized for the
//                   largest supported burst length (256)
//   beat_t        : burst position counter type
//   stream_beat_t : one delivered stream word {data, last}
//   beat_advance  : burst position increment with wrap at the final beat
// -----------------------------------------------------------------------------
package fifo_package;

    localparam int DATA_W_DEF    = 8;
    localparam int BURST_LEN_MAX = 256;
    localparam int BEAT_W        = $clog2(BURST_LEN_MAX + 1);

    typedef logic [BEAT_W-1:0] beat_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
    } stream_beat_t;

    // Next burst position: wraps to zero after the final beat of a burst.
    function automatic beat_t beat_advance(input beat_t beat, input beat_t last_beat);
        beat_t nxt;
        if (beat == last_beat) begin
            nxt = '0;
        end else begin
            nxt = beat + beat_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid2.sv
// -----------------------------------------------------------------------------
// fifo_skid2
// Two-entry, fully registered, in-order skid buffer. There is no bypass from
// din to head: a pushed word appears on head no earlier than the next cycle.
// Ports:
//   clk      : clock
//   rst      : synchronous active-low reset
//   push     : capture din this cycle
//   pop      : head consumed this cycle (ignored while empty)
//   din      : word to capture
//   head     : oldest held word (registered)
//   valid    : head holds a word (registered)
//   occ      : entries held, 0..2
//   occ_next : occupancy after this cycle's push/pop
// -----------------------------------------------------------------------------
module fifo_skid2
    import fifo_package::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic [1:0]        occ,
    output logic [1:0]        occ_next
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        occ_q, occ_d;
    logic              valid_q, valid_d;
    logic              pop_s;
    logic              push_s;

    // A pop on an empty buffer, or a push into a full one without a pop, is
    // dropped so the occupancy can never leave 0..2.
    assign pop_s  = pop & (occ_q != 2'd0);
    assign push_s = push & ((occ_q != 2'd2) | pop_s);

    // Next-state of the two entries and the occupancy.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_s, pop_s})
            2'b10: begin
                case (occ_q)
                    2'd0:    head_d = din;
                    2'd1:    tail_d = din;
                    default: tail_d = tail_q;
                endcase
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged: the second entry advances and the new
                // word queues behind it (or becomes head if it was alone).
                if (occ_q == 2'd1) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
        valid_d = (occ_d != 2'd0);
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign head     = head_q;
    assign valid    = valid_q;
    assign occ      = occ_q;
    assign occ_next = occ_d;

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Read-side master for a FIFO with one cycle of read latency. Words are pulled
// from the FIFO into a 2-entry skid buffer and presented as a valid/ready
// stream at up to one word per clock; every BURST_LEN-th delivered word is
// flagged with m_last, and delivered words are counted in words_out.
// Ports:
//   clk        : clock
//   rst        : synchronous active-low reset
//   enable     : allow new FIFO reads (buffered words drain regardless)
//   fifo_empty : FIFO empty flag
//   fifo_rd_en : FIFO read strobe
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd_en
//   m_valid    : output word valid
//   m_ready    : downstream accepts the word
//   m_data     : output word
//   m_last     : final word of a burst
//   words_out  : words accepted downstream since reset (wraps)
//   busy       : words buffered or a read in flight
// -----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_package::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CNT_W-1:0]  words_out,
    output logic              busy
);

    localparam beat_t LAST_BEAT = beat_t'(BURST_LEN - 1);

    logic             inflight_q, inflight_d;
    beat_t            beat_q, beat_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;

    logic             valid_s;
    logic             pop_s;
    logic             rd_en_s;
    logic [1:0]       occ_s;
    logic [1:0]       occ_next_s;
    logic [2:0]       fill_s;

    assign pop_s  = valid_s & m_ready;

    // Entries that will be committed once everything in flight lands; a new
    // read is only issued while that leaves room for its returning word.
    assign fill_s  = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign rd_en_s = rst & enable & ~fifo_empty & (fill_s < 3'd2);

    fifo_skid2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .pop      (pop_s),
        .din      (fifo_data),
        .head     (m_data),
        .valid    (valid_s),
        .occ      (occ_s),
        .occ_next (occ_next_s)
    );

    // Next-state of the burst position, word counter and registered flags.
    always_comb begin
        inflight_d = rd_en_s;
        if (pop_s) begin
            beat_d  = beat_advance(beat_q, LAST_BEAT);
            words_d = words_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            beat_d  = beat_q;
            words_d = words_q;
        end
        // m_last is evaluated against the word that will be at the head next.
        last_d = (occ_next_s != 2'd0) & (beat_d == LAST_BEAT);
        busy_d = (occ_next_s != 2'd0) | rd_en_s;
    end

    // Control and status registers; reset also drops any returning read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
            words_q    <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            words_q    <= words_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = valid_s;
    assign m_last     = last_q;
    assign words_out  = words_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
    import fifo_package::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_data = 8'h00;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [3:0] words_out;
    logic       busy;

    fifo_stream_reader #(
        .DATA_W    (8),
        .BURST_LEN (4),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .words_out  (words_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO with one cycle of read latency
    logic [7:0] fmem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush  = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_data <= fmem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Monitor on the falling edge: read strobes, empty-read violations, and
    // every word accepted downstream.
    int           cyc      = 0;
    int           rd_cnt   = 0;
    int           viol_cnt = 0;
    int           rx_n     = 0;
    stream_beat_t rx_log [0:63];
    int           rx_cyc [0:63];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (fifo_rd_en && fifo_empty) viol_cnt <= viol_cnt + 1;
        if (m_valid && m_ready) begin
            rx_log[rx_n[5:0]].data <= m_data;
            rx_log[rx_n[5:0]].last <= m_last;
            rx_cyc[rx_n[5:0]]      <= cyc;
            rx_n                   <= rx_n + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fifo_write(input logic [7:0] v);
        fmem[wr_ptr[7:0]] = v;
        wr_ptr++;
    endtask

    int base_rx;
    int base_rd;
    int n_last;
    logic [7:0] exp_b [0:3];

    initial begin
        rst     = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b0;

        // Reset state: reads are blocked by reset even with data available
        fifo_write(8'h01);
        fifo_write(8'h02);
        fifo_write(8'h03);
        tick(3);
        check("rst_m_valid", 32'(m_valid), 32'h0);
        check("rst_m_last", 32'(m_last), 32'h0);
        check("rst_m_data", 32'(m_data), 32'h0);
        check("rst_words_out", 32'(words_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rd_en_forced", 32'(fifo_rd_en), 32'h0);

        // 1. Reset mid-stream: a read is issued, then reset drops its word
        rst = 1'b1;
        #1;
        check("t1_rd_en_issue", 32'(fifo_rd_en), 32'h1);
        tick(1);
        rst = 1'b0;
        #1;
        check("t1_rd_en_in_rst", 32'(fifo_rd_en), 32'h0);
        tick(1);
        check("t1_m_valid", 32'(m_valid), 32'h0);
        check("t1_busy", 32'(busy), 32'h0);
        check("t1_words_out", 32'(words_out), 32'h0);
        enable = 1'b0;
        rst    = 1'b1;
        tick(2);
        check("t1_dropped_valid", 32'(m_valid), 32'h0);
        check("t1_dropped_busy", 32'(busy), 32'h0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;

        // 2. Streaming at one word per clock
        fifo_write(8'h11);
        fifo_write(8'h22);
        fifo_write(8'h33);
        fifo_write(8'h44);
        fifo_write(8'h55);
        base_rx = rx_n;
        base_rd = rd_cnt;
        m_ready = 1'b1;
        enable  = 1'b1;
        #1;
        check("t2_first_rd_en", 32'(fifo_rd_en), 32'h1);
        tick(1);
        check("t2_valid_lat1", 32'(m_valid), 32'h0);
        tick(1);
        check("t2_valid_lat2", 32'(m_valid), 32'h1);
        check("t2_data_lat2", 32'(m_data), 32'h11);
        tick(8);
        check("t2_rx_count", 32'(rx_n - base_rx), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("t2_rx_data", 32'(rx_log[base_rx + i].data), 32'(8'h11 * (i + 1)));
            check("t2_rx_last", 32'(rx_log[base_rx + i].last), (i == 3) ? 32'h1 : 32'h0);
        end
        check("t2_consecutive", 32'(rx_cyc[base_rx + 4] - rx_cyc[base_rx]), 32'd4);
        check("t2_rd_count", 32'(rd_cnt - base_rd), 32'd5);
        check("t2_words_out", 32'(words_out), 32'd5);
        check("t2_busy_idle", 32'(busy), 32'h0);

        // 3. Backpressure: only two reads fit, head held stable
        fifo_write(8'h11);
        fifo_write(8'h22);
        fifo_write(8'h33);
        fifo_write(8'h44);
        m_ready = 1'b0;
        base_rd = rd_cnt;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            if (i >= 2) begin
                check("t3_hold_valid", 32'(m_valid), 32'h1);
                check("t3_hold_data", 32'(m_data), 32'h11);
            end
        end
        check("t3_rd_count", 32'(rd_cnt - base_rd), 32'd2);
        check("t3_hold_last", 32'(m_last), 32'h0);
        base_rx = rx_n;
        m_ready = 1'b1;
        tick(8);
        check("t3_rx_count", 32'(rx_n - base_rx), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t3_rx_data", 32'(rx_log[base_rx + i].data), 32'(8'h11 * (i + 1)));
            check("t3_rx_last", 32'(rx_log[base_rx + i].last), (i == 2) ? 32'h1 : 32'h0);
        end
        check("t3_words_out", 32'(words_out), 32'd9);

        // 4. Empty boundary: no reads while empty, late word continues bursts
        base_rx = rx_n;
        fifo_write(8'h66);
        tick(6);
        check("t4_rx_count1", 32'(rx_n - base_rx), 32'd1);
        check("t4_rx_data0", 32'(rx_log[base_rx].data), 32'h66);
        check("t4_rx_last0", 32'(rx_log[base_rx].last), 32'h0);
        tick(3);
        fifo_write(8'hA5);
        tick(5);
        check("t4_rx_count2", 32'(rx_n - base_rx), 32'd2);
        check("t4_rx_data1", 32'(rx_log[base_rx + 1].data), 32'hA5);
        check("t4_rx_last1", 32'(rx_log[base_rx + 1].last), 32'h0);
        check("t4_empty_reads", 32'(viol_cnt), 32'd0);
        check("t4_words_out", 32'(words_out), 32'd11);

        // 5. Enable gating with the pipeline full
        for (int i = 0; i < 6; i++) fifo_write(8'hB0 + 8'(i));
        m_ready = 1'b0;
        tick(3);
        check("t5_full_valid", 32'(m_valid), 32'h1);
        check("t5_full_data", 32'(m_data), 32'hB0);
        check("t5_full_last", 32'(m_last), 32'h1);
        base_rx = rx_n;
        m_ready = 1'b1;
        tick(1);
        enable  = 1'b0;
        base_rd = rd_cnt;
        check("t5_busy_drain", 32'(busy), 32'h1);
        tick(4);
        check("t5_rx_count", 32'(rx_n - base_rx), 32'd3);
        exp_b[0] = 8'hB0;
        exp_b[1] = 8'hB1;
        exp_b[2] = 8'hB2;
        for (int i = 0; i < 3; i++) begin
            check("t5_rx_data", 32'(rx_log[base_rx + i].data), 32'(exp_b[i]));
            check("t5_rx_last", 32'(rx_log[base_rx + i].last), (i == 0) ? 32'h1 : 32'h0);
        end
        check("t5_no_reads", 32'(rd_cnt - base_rd), 32'd0);
        check("t5_busy_idle", 32'(busy), 32'h0);
        check("t5_valid_idle", 32'(m_valid), 32'h0);
        check("t5_words_out", 32'(words_out), 32'd14);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;

        // 6. Counter wrap: 17 words into a 4-bit counter
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("t6_words_cleared", 32'(words_out), 32'd0);
        for (int i = 0; i < 17; i++) fifo_write(8'h40 + 8'(i));
        base_rx = rx_n;
        enable  = 1'b1;
        m_ready = 1'b1;
        tick(25);
        check("t6_rx_count", 32'(rx_n - base_rx), 32'd17);
        check("t6_words_wrap", 32'(words_out), 32'd1);
        check("t6_last_15", 32'(rx_log[base_rx + 15].last), 32'h1);
        check("t6_last_16", 32'(rx_log[base_rx + 16].last), 32'h0);
        check("t6_data_16", 32'(rx_log[base_rx + 16].data), 32'h50);
        n_last = 0;
        for (int i = 0; i < 17; i++) n_last += int'(rx_log[base_rx + i].last);
        check("t6_last_total", 32'(n_last), 32'd4);
        check("t6_empty_reads", 32'(viol_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side master for the FIFO block. It drives the FIFO read port (rd_en, data_out, empty) and presents the words as a valid/ready output stream.
- A 2-entry skid buffer hides the FIFO's 1-cycle read latency, so the stream sustains 1 word/clock under backpressure.
- It marks burst boundaries with m_last and keeps a running count of delivered words.
- It sits between the FIFO and any downstream consumer (checker, serializer).

Parameters:
- DATA_W, 8, width of FIFO data and stream data.
- BURST_LEN, 4, words per burst; m_last is asserted on every BURST_LEN-th delivered word (range 1..256).
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- enable  in  1  1 allows new FIFO reads; 0 stops reads, and buffered words still drain.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  read strobe to the FIFO.
- fifo_data  in  DATA_W  FIFO data_out, valid on the cycle after fifo_rd_en.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  DATA_W  output word.
- m_last  out  1  final word of the current burst (qualified by m_valid).
- words_out  out  CNT_W  total words accepted downstream since reset (wraps).
- busy  out  1  1 while occ != 0 or inflight == 1.

Behaviour:
- Reset (rst==0 at posedge):
  - occ=0, inflight=0, beat=0, words_out=0.
  - m_valid=0, m_last=0, m_data=0.
  - fifo_rd_en is forced to 0 combinationally while rst==0.
- State:
  - occ: skid entries held, 0..2.
  - inflight: 1 if fifo_rd_en was high last cycle.
  - beat: position in burst, 0..BURST_LEN-1.
- Events:
  - pop = m_valid & m_ready.
  - push = inflight, meaning fifo_data is captured this cycle.
- Read issue (combinational): fifo_rd_en = rst & enable & ~fifo_empty & (occ + inflight - pop < 2).
  - Reads are never issued when fifo_empty=1.
  - The skid buffer never overflows.
- Skid buffer: a 2-entry FIFO, in order.
  - m_data shows the oldest entry; m_valid = (occ != 0), registered.
  - Same-cycle push and pop: occ unchanged; the next entry moves to the head, and the new word goes behind it.
  - push with occ==0 and pop==0: word goes to the head, shown the next cycle. Latency from fifo_rd_en to m_valid is 2 clocks.
  - No bypass path from fifo_data to m_data. The output is fully registered.
- Backpressure: m_data and m_last hold stable while m_valid=1 and m_ready=0.
- Burst marking:
  - m_last = m_valid & (beat == BURST_LEN-1).
  - On pop, beat increments and wraps to 0 after BURST_LEN-1.
  - BURST_LEN=1 means every word is last.
- Counter: words_out increments by 1 on each pop and wraps modulo 2^CNT_W.
- enable falling: no new reads. An in-flight word is still captured, and buffered words drain normally.
- Reset mid-operation: state clears the same cycle. A word returning from a read issued before reset is discarded; inflight is cleared.
- Throughput: with m_ready=1 and the FIFO non-empty, fifo_rd_en stays high every cycle and m_valid stays high every cycle after the initial 2-cycle fill.

Decomposition:
- Shared package fifo_package gets:
  - the DATA_W default constant;
  - a beat counter typedef sized $clog2(BURST_LEN+1);
  - a stream beat struct {data, last} for bench transactions.
- One sub-module: fifo_skid2, a 2-entry registered skid buffer with push/pop/occ. The burst counter, word counter and read-issue logic stay in the top.

Test Plan:
1. Reset mid-stream:
   - Stimulus: FIFO holds 3 words, rd_en issued, then rst=0 for one cycle.
   - Response: the next cycle has m_valid=0, busy=0 and words_out=0; the returning word is dropped.
2. Streaming:
   - Stimulus: FIFO preloaded 0x11,0x22,0x33,0x44,0x55; m_ready=1; enable=1.
   - Response: m_data 0x11..0x55 on consecutive cycles, starting 2 clocks after the first rd_en; m_last=1 on 0x44 only; words_out=5.
3. Backpressure:
   - Stimulus: m_ready=0 for 6 cycles with the FIFO holding 4 words.
   - Response: exactly 2 reads issued; m_data holds 0x11 stable.
   - Then m_ready=1: remaining words delivered in order, with no loss or duplication.
4. Empty boundary:
   - Stimulus: FIFO goes empty after 1 word.
   - Response: fifo_rd_en=0 on every cycle where fifo_empty=1.
   - Then a write of 0xA5: delivered with m_last=0 and beat continuing from 1.
5. Enable gating:
   - Stimulus: enable=0 with occ=2, inflight=1, m_ready=1.
   - Response: 3 words delivered, no further rd_en, busy falls to 0.
6. Counter wrap:
   - Stimulus: CNT_W=4, stream 17 words.
   - Response: words_out=1.
